// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the 2-write/4-read register file
// Optional build macro REGFILE_FORWARD_EN enables same-cycle write-to-read bypass.
`ifndef XLEN
`define XLEN 32
`endif

package regfile_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = $clog2(NUM_REGS);

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [`XLEN-1:0]     reg_data_t;

   // A write port can only bypass into a read when it really updates a stored register.
   function automatic logic fwd_hit(input logic we, input reg_idx_t widx, input reg_idx_t ridx);
      return we && (widx != '0) && (widx == ridx);
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port: storage mux, x0 zeroing, optional bypass
// Bypass compare against both write ports is built only when REGFILE_FORWARD_EN is defined.
module regfile_read_port
   import regfile_pkg::*;
(
   input  logic                       reset,
   input  reg_idx_t                   idx,
   input  reg_data_t [NUM_REGS-1:0]   file,
   input  logic                       we_1,
   input  reg_idx_t                   widx_1,
   input  reg_data_t                  wdata_1,
   input  logic                       we_2,
   input  reg_idx_t                   widx_2,
   input  reg_data_t                  wdata_2,
   output reg_data_t                  data
);

`ifdef REGFILE_FORWARD_EN
   always_comb begin
      data = file[idx];
      // Lane 2 is younger, so its bypass is applied last and overrides lane 1.
      if (fwd_hit(we_1, widx_1, idx)) data = wdata_1;
      if (fwd_hit(we_2, widx_2, idx)) data = wdata_2;
      if (reset || idx == '0) data = '0;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{we_1, widx_1, wdata_1, we_2, widx_2, wdata_2};

   always_comb begin
      data = file[idx];
      if (reset || idx == '0) data = '0;
   end
`endif

endmodule

// File: rtl/regfile_2w4r.sv
// rtl/regfile_2w4r.sv - 32 x XLEN architectural register file, two write and four read ports
// Define REGFILE_FORWARD_EN to bypass same-cycle write data onto all four read ports.
module regfile_2w4r
   import regfile_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  reg_idx_t  readA_idx_1,
   input  reg_idx_t  readB_idx_1,
   input  reg_idx_t  readA_idx_2,
   input  reg_idx_t  readB_idx_2,
   input  reg_idx_t  write_idx_1,
   input  reg_idx_t  write_idx_2,
   input  logic      write_en_1,
   input  logic      write_en_2,
   input  reg_data_t write_data_1,
   input  reg_data_t write_data_2,
   output reg_data_t readA_out_1,
   output reg_data_t readB_out_1,
   output reg_data_t readA_out_2,
   output reg_data_t readB_out_2
);

   reg_data_t               regs [NUM_REGS-1:1];
   reg_data_t [NUM_REGS-1:0] file;

   // Lane 2's assignment comes last so a same-index double write keeps lane 2's data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (write_en_1 && write_idx_1 != '0) regs[write_idx_1] <= write_data_1;
         if (write_en_2 && write_idx_2 != '0) regs[write_idx_2] <= write_data_2;
      end
   end

   always_comb begin
      file[0] = '0;
      for (int i = 1; i < NUM_REGS; i++) file[i] = regs[i];
   end

   regfile_read_port u_rd_a1 (
      .reset(reset), .idx(readA_idx_1), .file(file),
      .we_1(write_en_1), .widx_1(write_idx_1), .wdata_1(write_data_1),
      .we_2(write_en_2), .widx_2(write_idx_2), .wdata_2(write_data_2),
      .data(readA_out_1)
   );

   regfile_read_port u_rd_b1 (
      .reset(reset), .idx(readB_idx_1), .file(file),
      .we_1(write_en_1), .widx_1(write_idx_1), .wdata_1(write_data_1),
      .we_2(write_en_2), .widx_2(write_idx_2), .wdata_2(write_data_2),
      .data(readB_out_1)
   );

   regfile_read_port u_rd_a2 (
      .reset(reset), .idx(readA_idx_2), .file(file),
      .we_1(write_en_1), .widx_1(write_idx_1), .wdata_1(write_data_1),
      .we_2(write_en_2), .widx_2(write_idx_2), .wdata_2(write_data_2),
      .data(readA_out_2)
   );

   regfile_read_port u_rd_b2 (
      .reset(reset), .idx(readB_idx_2), .file(file),
      .we_1(write_en_1), .widx_1(write_idx_1), .wdata_1(write_data_1),
      .we_2(write_en_2), .widx_2(write_idx_2), .wdata_2(write_data_2),
      .data(readB_out_2)
   );

endmodule

// File: tb/tb_regfile_2w4r.sv
// tb/tb_regfile_2w4r.sv - self-checking bench for regfile_2w4r (directed + randomized)
// Expectations follow REGFILE_FORWARD_EN when it is defined for the build.
module tb_regfile_2w4r;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  ridx [4];
   logic [4:0]  widx_1, widx_2;
   logic        we_1, we_2;
   logic [31:0] wd_1, wd_2;
   logic [31:0] outs [4];
   logic [31:0] model [32];
   int          checks = 0;
   int          errors = 0;

   always #5 clock = ~clock;

   regfile_2w4r dut (
      .clock(clock), .reset(reset),
      .readA_idx_1(ridx[0]), .readB_idx_1(ridx[1]),
      .readA_idx_2(ridx[2]), .readB_idx_2(ridx[3]),
      .write_idx_1(widx_1), .write_idx_2(widx_2),
      .write_en_1(we_1), .write_en_2(we_2),
      .write_data_1(wd_1), .write_data_2(wd_2),
      .readA_out_1(outs[0]), .readB_out_1(outs[1]),
      .readA_out_2(outs[2]), .readB_out_2(outs[3])
   );

`ifdef REGFILE_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // Reference: what architectural state says a read must return this instant.
   function automatic logic [31:0] expect_rd(input logic [4:0] idx);
      if (reset || idx == 0) return 32'h0;
      if (FWD && we_2 && widx_2 == idx) return wd_2;
      if (FWD && we_1 && widx_1 == idx) return wd_1;
      return model[idx];
   endfunction

   task automatic clock_edge();
      @(posedge clock);
      if (!reset) begin
         if (we_1 && widx_1 != 0) model[widx_1] = wd_1;
         if (we_2 && widx_2 != 0) model[widx_2] = wd_2;
      end
      #1;
   endtask

   task automatic idle_writes();
      we_1 = 0; we_2 = 0; widx_1 = 0; widx_2 = 0; wd_1 = 0; wd_2 = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int r = 0; r < 32; r++) model[r] = 32'h0;
      idle_writes();
      ridx[0] = 5'd1; ridx[1] = 5'd7; ridx[2] = 5'd19; ridx[3] = 5'd31;
      #2;
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (outs[p] !== 32'h0) begin
            errors++;
            $display("FAIL reset_out port%0d: got %h expected 00000000", p, outs[p]);
         end
      end
      we_1 = 1; widx_1 = 5'd7; wd_1 = 32'h5555_5555;
      clock_edge();
      @(negedge clock);
      reset = 1'b0;
      idle_writes();
      #1;
      checks++;
      if (outs[1] !== 32'h0) begin
         errors++;
         $display("FAIL reset_write_ignored: got %h expected 00000000", outs[1]);
      end
      clock_edge();
   endtask

   task automatic test_directed();
      logic [31:0] pre;
      // Successive writes, then read back on lane-1 ports.
      we_1 = 1; widx_1 = 5'd5;  wd_1 = 32'hDEAD_BEEF; clock_edge();
      widx_1 = 5'd10; wd_1 = 32'hCAFE_BABE; clock_edge();
      idle_writes();
      ridx[0] = 5'd5; ridx[1] = 5'd10; #2;
      checks++;
      if (outs[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_a1_r5: got %h expected deadbeef", outs[0]); end
      checks++;
      if (outs[1] !== 32'hCAFE_BABE) begin errors++; $display("FAIL rd_b1_r10: got %h expected cafebabe", outs[1]); end
      clock_edge();

      // x0 write dropped, x0 reads zero even while being written.
      we_1 = 1; widx_1 = 5'd0; wd_1 = 32'hFFFF_FFFF;
      for (int p = 0; p < 4; p++) ridx[p] = 5'd0;
      #2;
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (outs[p] !== 32'h0) begin errors++; $display("FAIL x0_fwd port%0d: got %h expected 00000000", p, outs[p]); end
      end
      clock_edge();
      idle_writes(); #2;
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (outs[p] !== 32'h0) begin errors++; $display("FAIL x0_after port%0d: got %h expected 00000000", p, outs[p]); end
      end
      clock_edge();

      // Same-cycle read of a register being written.
      we_1 = 1; widx_1 = 5'd15; wd_1 = 32'hAAAA_AAAA; ridx[0] = 5'd15; #2;
      pre = FWD ? 32'hAAAA_AAAA : 32'h0;
      checks++;
      if (outs[0] !== pre) begin errors++; $display("FAIL fwd_r15_pre: got %h expected %h", outs[0], pre); end
      clock_edge();
      idle_writes(); #2;
      checks++;
      if (outs[0] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL r15_post: got %h expected aaaaaaaa", outs[0]); end

      // All four ports at once.
      ridx[0] = 5'd5; ridx[1] = 5'd10; ridx[2] = 5'd15; ridx[3] = 5'd0; #2;
      checks++;
      if ({outs[0], outs[1], outs[2], outs[3]} !== {32'hDEAD_BEEF, 32'hCAFE_BABE, 32'hAAAA_AAAA, 32'h0}) begin
         errors++;
         $display("FAIL all_ports: got %h %h %h %h expected deadbeef cafebabe aaaaaaaa 00000000", outs[0], outs[1], outs[2], outs[3]);
      end
      clock_edge();

      // Double write to one index: lane 2 wins both in bypass and in storage.
      we_1 = 1; widx_1 = 5'd20; wd_1 = 32'h1111_1111;
      we_2 = 1; widx_2 = 5'd20; wd_2 = 32'h2222_2222;
      ridx[3] = 5'd20; #2;
      pre = FWD ? 32'h2222_2222 : 32'h0;
      checks++;
      if (outs[3] !== pre) begin errors++; $display("FAIL dbl_write_pre: got %h expected %h", outs[3], pre); end
      clock_edge();
      idle_writes(); #2;
      checks++;
      if (outs[3] !== 32'h2222_2222) begin errors++; $display("FAIL dbl_write_post: got %h expected 22222222", outs[3]); end
      clock_edge();
   endtask

   task automatic test_reset_mid_run();
      we_2 = 1; widx_2 = 5'd25; wd_2 = 32'h1234_5678; clock_edge();
      idle_writes();
      ridx[0] = 5'd5; ridx[1] = 5'd10; ridx[2] = 5'd20; ridx[3] = 5'd25; #2;
      checks++;
      if (outs[3] !== 32'h1234_5678) begin errors++; $display("FAIL r25_before_reset: got %h expected 12345678", outs[3]); end
      reset = 1'b1;
      for (int r = 0; r < 32; r++) model[r] = 32'h0;
      #1;
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (outs[p] !== 32'h0) begin errors++; $display("FAIL async_reset port%0d: got %h expected 00000000", p, outs[p]); end
      end
      we_1 = 1; widx_1 = 5'd25; wd_1 = 32'h9999_9999; #1;
      checks++;
      if (outs[3] !== 32'h0) begin errors++; $display("FAIL fwd_in_reset: got %h expected 00000000", outs[3]); end
      clock_edge();
      @(negedge clock);
      reset = 1'b0;
      idle_writes(); #1;
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (outs[p] !== 32'h0) begin errors++; $display("FAIL after_reset port%0d: got %h expected 00000000", p, outs[p]); end
      end
      clock_edge();
   endtask

   task automatic test_random();
      logic [31:0] exp_v;
      for (int n = 0; n < 400; n++) begin
         we_1 = 1'($urandom_range(0, 1)); widx_1 = 5'($urandom_range(0, 31)); wd_1 = $urandom;
         we_2 = 1'($urandom_range(0, 1)); widx_2 = ($urandom_range(0, 3) == 0) ? widx_1 : 5'($urandom_range(0, 31));
         wd_2 = $urandom;
         for (int p = 0; p < 4; p++) begin
            case ($urandom_range(0, 3))
               0:       ridx[p] = widx_1;
               1:       ridx[p] = widx_2;
               default: ridx[p] = 5'($urandom_range(0, 31));
            endcase
         end
         #2;
         for (int p = 0; p < 4; p++) begin
            exp_v = expect_rd(ridx[p]);
            checks++;
            if (outs[p] !== exp_v) begin
               errors++;
               $display("FAIL random_read iter%0d port%0d idx%0d: got %h expected %h", n, p, ridx[p], outs[p], exp_v);
            end
         end
         clock_edge();
      end
      idle_writes();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
